cache_assoc_array: RTL

//  N-way set-associative tag/data store for the L1 instruction/data caches.
//  - Generalises the direct-mapped tag/data RAM: per-way valid bits, hit detection, victim selection, flush.
//  - Lookups answer one cycle after acceptance; fills choose a victim way internally.
//  - Sits between the cache controller FSM and the memory fill path.

---
 rtl/cache_pkg.sv | 19 +
 rtl/cache_way_ram.sv | 46 ++++
 rtl/cache_assoc_array.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared types and default widths for the set-associative cache array.
// Provides the controller state enum and the way-index width helper.
package cache_pkg;

  typedef enum logic {
    CS_INIT,
    CS_READY
  } cache_state_e;

  localparam int TAG_W     = 17;
  localparam int LINE_W    = 512;
  localparam int SETS_LOG2 = 10;

  // Way index width; a direct-mapped array still gets a 1-bit index.
  function automatic int way_w(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/cache_way_ram.sv
// One way of the cache: tag + data array, one write port, one
// registered read port (read-before-write), plus a tag peek for fills.
// Ports: clk; we/waddr/wtag/wdata write; re/raddr -> rtag/rdata
// (one cycle later); paddr -> ptag (same cycle, victim search).
module cache_way_ram
  import cache_pkg::*;
#(
  parameter int SETS_LOG2 = cache_pkg::SETS_LOG2,
  parameter int TAG_W     = cache_pkg::TAG_W,
  parameter int LINE_W    = cache_pkg::LINE_W
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [SETS_LOG2-1:0] waddr,
  input  logic [TAG_W-1:0]     wtag,
  input  logic [LINE_W-1:0]    wdata,
  input  logic                 re,
  input  logic [SETS_LOG2-1:0] raddr,
  output logic [TAG_W-1:0]     rtag,
  output logic [LINE_W-1:0]    rdata,
  input  logic [SETS_LOG2-1:0] paddr,
  output logic [TAG_W-1:0]     ptag
);

  localparam int SETS = 2 ** SETS_LOG2;

  logic [TAG_W-1:0]  tag_mem  [SETS];
  logic [LINE_W-1:0] data_mem [SETS];

  // Non-blocking write + read in one block gives old data on collision.
  always_ff @(posedge clk) begin
    if (we) begin
      tag_mem[waddr]  <= wtag;
      data_mem[waddr] <= wdata;
    end
    if (re) begin
      rtag  <= tag_mem[raddr];
      rdata <= data_mem[raddr];
    end
  end

  // The fill commits at the edge that accepts it, so its
  // rewrite check needs the stored tags combinationally.
  assign ptag = tag_mem[paddr];

endmodule

// File: rtl/cache_assoc_array.sv
// N-way set-associative tag/data store: hit detection, victim choice,
// flush sweep. Macro CACHE_STATS_EN enables the hit/miss counters.
// Ports: clk, rstn (sync, active low), ready; lookup_* request ->
// resp_* one cycle later; fill_* request -> fill_done/fill_way;
// flush_req; hit_count/miss_count.
module cache_assoc_array
  import cache_pkg::*;
#(
  parameter int WAYS      = 2,
  parameter int SETS_LOG2 = cache_pkg::SETS_LOG2,
  parameter int TAG_W     = cache_pkg::TAG_W,
  parameter int LINE_W    = cache_pkg::LINE_W
) (
  input  logic                     clk,
  input  logic                     rstn,
  output logic                     ready,
  input  logic                     lookup_valid,
  input  logic [SETS_LOG2-1:0]     lookup_index,
  input  logic [TAG_W-1:0]         lookup_tag,
  output logic                     resp_valid,
  output logic                     resp_hit,
  output logic [way_w(WAYS)-1:0]   resp_way,
  output logic [LINE_W-1:0]        resp_data,
  input  logic                     fill_valid,
  input  logic [SETS_LOG2-1:0]     fill_index,
  input  logic [TAG_W-1:0]         fill_tag,
  input  logic [LINE_W-1:0]        fill_data,
  output logic                     fill_done,
  output logic [way_w(WAYS)-1:0]   fill_way,
  input  logic                     flush_req,
  output logic [31:0]              hit_count,
  output logic [31:0]              miss_count
);

  localparam int WW   = way_w(WAYS);
  localparam int SETS = 2 ** SETS_LOG2;

  cache_state_e         state;
  logic [SETS_LOG2-1:0] sweep;
  logic [WAYS-1:0]      valid [SETS];

  logic lk_acc;
  logic fl_acc;
  logic lk_q;
  logic [TAG_W-1:0] lk_tag_q;
  logic [WAYS-1:0]  lk_vld_q;

  logic [TAG_W-1:0]  rtag  [WAYS];
  logic [TAG_W-1:0]  ptag  [WAYS];
  logic [LINE_W-1:0] rdata [WAYS];
  logic [WAYS-1:0]   we;
  logic [WAYS-1:0]   set_vld;
  logic [WW-1:0]     victim;
  logic [WW-1:0]     rr_cur;
  logic              use_rr;

  assign ready  = (state == CS_READY);
  assign lk_acc = lookup_valid & ready;
  assign fl_acc = fill_valid & ready;

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    cache_way_ram #(
      .SETS_LOG2(SETS_LOG2),
      .TAG_W    (TAG_W),
      .LINE_W   (LINE_W)
    ) u_ram (
      .clk  (clk),
      .we   (we[g]),
      .waddr(fill_index),
      .wtag (fill_tag),
      .wdata(fill_data),
      .re   (lk_acc),
      .raddr(lookup_index),
      .rtag (rtag[g]),
      .rdata(rdata[g]),
      .paddr(fill_index),
      .ptag (ptag[g])
    );
  end

  // Victim: existing tag, else lowest invalid, else round robin.
  // Descending loops let the lowest qualifying way win.
  always_comb begin
    set_vld = valid[fill_index];
    victim  = rr_cur;
    use_rr  = 1'b1;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!set_vld[w]) begin
        victim = WW'(w);
        use_rr = 1'b0;
      end
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (set_vld[w] && ptag[w] == fill_tag) begin
        victim = WW'(w);
        use_rr = 1'b0;
      end
    end
    for (int w = 0; w < WAYS; w++) begin
      we[w] = fl_acc && (victim == WW'(w));
    end
  end

  if (WAYS > 1) begin : g_rr
    logic [WW-1:0] rr [SETS];
    always_ff @(posedge clk) begin
      if (rstn) begin
        if (state == CS_INIT) begin
          rr[sweep] <= '0;
        end else if (fl_acc && use_rr) begin
          rr[fill_index] <= rr[fill_index] + 1'b1;
        end
      end
    end
    assign rr_cur = rr[fill_index];
  end else begin : g_no_rr
    assign rr_cur = '0;
  end

  // Valid bits are cleared only by the sweep, never by reset itself.
  always_ff @(posedge clk) begin
    if (rstn) begin
      if (state == CS_INIT) begin
        valid[sweep] <= '0;
      end else if (fl_acc) begin
        valid[fill_index] <= set_vld | we;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= CS_INIT;
      sweep     <= '0;
      lk_q      <= 1'b0;
      fill_done <= 1'b0;
      fill_way  <= '0;
    end else begin
      lk_q      <= lk_acc;
      fill_done <= fl_acc;
      if (fl_acc) begin
        fill_way <= victim;
      end
      unique case (state)
        CS_INIT: begin
          sweep <= sweep + 1'b1;
          if (&sweep) begin
            state <= CS_READY;
          end
        end
        CS_READY: begin
          if (flush_req) begin
            state <= CS_INIT;
            sweep <= '0;
          end
        end
        default: state <= CS_INIT;
      endcase
    end
  end

  // Valid bits are sampled with the request so a same-cycle
  // fill cannot make the lookup see post-fill state.
  always_ff @(posedge clk) begin
    if (lk_acc) begin
      lk_tag_q <= lookup_tag;
      lk_vld_q <= valid[lookup_index];
    end
  end

  always_comb begin
    resp_valid = lk_q;
    resp_hit   = 1'b0;
    resp_way   = '0;
    resp_data  = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (lk_q && lk_vld_q[w] && rtag[w] == lk_tag_q) begin
        resp_hit  = 1'b1;
        resp_way  = WW'(w);
        resp_data = rdata[w];
      end
    end
  end

`ifdef CACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (resp_valid) begin
      if (resp_hit) begin
        if (hit_count != '1) hit_count <= hit_count + 1'b1;
      end else begin
        if (miss_count != '1) miss_count <= miss_count + 1'b1;
      end
    end
  end
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule
